// File: rtl/parallax_starfield.sv
// parallax_starfield
//   Procedural scrolling starfield. After reset or a reseed pulse, a star table is
//   filled one entry per cycle from a free-running 16-bit Galois LFSR. In RUN,
//   each frame pulse scrolls the stars upward by a per-layer step that depends on
//   the game state. A frame counter advances the twinkle phase of every star.
//   Every pixel clock, the current (hpos, vpos) is looked up against the table.
//   The colour of the winning star is registered onto the pixel output.
//
// Ports
//   pixel_clk   sole clock, rising edge
//   rst         asynchronous active-high reset
//   fsync       one-cycle frame-start pulse (ignored during INIT)
//   hpos, vpos  signed 12-bit current pixel column / row
//   game_state  00 title, 01 play, 10 pause, 11 game over
//   reseed      one-cycle pulse, regenerate the star table
//   pixel       registered colour, [0]=B [1]=G [2]=R
//   active      registered star-hit flag, aligned with pixel
//   init_done   high while the star table is valid
module parallax_starfield #(
    parameter int          STAR_COUNT  = 64,
    parameter int          LAYERS      = 3,
    parameter int          AREA_H      = 640,
    parameter int          AREA_V      = 480,
    parameter int          TWINKLE_DIV = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic [1:0]         game_state,
    input  logic               reseed,
    output logic [2:0][7:0]    pixel,
    output logic               active,
    output logic               init_done
);

    localparam logic [1:0] GS_TITLE = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;
    localparam logic [1:0] GS_PAUSE = 2'b10;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Upward scroll distance for one frame
    function automatic logic [11:0] y_step(input logic [1:0] gs, input logic [1:0] layer);
        case (gs)
            GS_PLAY:  y_step = {10'd0, layer} + 12'd1;
            GS_TITLE: y_step = 12'd1;
            default:  y_step = 12'd0;
        endcase
    endfunction

    // Layer brightness, tint and twinkle folded into a {R,G,B} word
    function automatic logic [23:0] star_colour(input logic [1:0] layer,
                                                input logic [1:0] tint,
                                                input logic [3:0] phase);
        logic [8:0] sum;
        logic [7:0] base;
        sum  = 9'd64 + {1'b0, layer, 6'd0};
        base = sum[8] ? 8'hFF : sum[7:0];
        if (phase[3]) begin
            base = base >> 1;
        end else begin
            base = base;
        end
        case (tint)
            2'b01:   star_colour = {8'h00, 8'h00, base};
            2'b10:   star_colour = {base, base, 8'h00};
            default: star_colour = {base, base, base};
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  idx_r, idx_s;
    logic        init_done_r, init_done_s;
    logic        wr_en_s;
    logic [15:0] lfsr_r;
    logic [7:0]  frame_r;
    logic        run_fsync_s, twinkle_s;
    logic [2:0][7:0] pixel_r;
    logic        active_r;

    // The star table has no reset; it only becomes visible once init_done is set
    logic [11:0] star_x     [STAR_COUNT];
    logic [11:0] star_y     [STAR_COUNT];
    logic [1:0]  star_layer [STAR_COUNT];
    logic [3:0]  star_phase [STAR_COUNT];
    logic [1:0]  star_tint  [STAR_COUNT];

    logic [11:0] new_x_s, new_y_s;
    logic [1:0]  new_layer_s;

    logic [11:0] h_u_s, v_u_s;
    logic        pos_ok_s, hit_s;
    logic [1:0]  best_layer_s;
    logic [23:0] colour_s;

    // State, index and init_done registers
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_INIT;
            idx_r       <= 8'd0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            init_done_r <= init_done_s;
        end
    end

    // Next-state: fill one star per cycle, reseed restarts the fill at index 0
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        init_done_s = init_done_r;
        wr_en_s     = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (reseed) begin
                    idx_s = 8'd0;
                end else if (idx_r == 8'(STAR_COUNT - 1)) begin
                    wr_en_s     = 1'b1;
                    idx_s       = 8'd0;
                    state_s     = ST_RUN;
                    init_done_s = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                    idx_s   = idx_r + 8'd1;
                end
            end
            ST_RUN: begin
                if (reseed) begin
                    state_s     = ST_INIT;
                    idx_s       = 8'd0;
                    init_done_s = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s     = ST_INIT;
                idx_s       = 8'd0;
                init_done_s = 1'b0;
            end
        endcase
    end

    // Free-running LFSR; reseed deliberately does not touch it
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Frame-level controls derived from fsync in RUN
    always_comb begin
        run_fsync_s = (state_r == ST_RUN) && fsync && !reseed;
        twinkle_s   = run_fsync_s && (frame_r == 8'(TWINKLE_DIV - 1)) && (game_state != GS_PAUSE);
        new_x_s     = 12'(32'(lfsr_r[11:0]) % AREA_H);
        new_y_s     = 12'(32'(lfsr_r[15:4]) % AREA_V);
        new_layer_s = 2'(32'(idx_r) % LAYERS);
    end

    // Frame counter, wraps every TWINKLE_DIV frames
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            frame_r <= 8'd0;
        end else if (run_fsync_s) begin
            frame_r <= (frame_r == 8'(TWINKLE_DIV - 1)) ? 8'd0 : frame_r + 8'd1;
        end else begin
            frame_r <= frame_r;
        end
    end

    // Star table: written during INIT, scrolled and twinkled on frame pulses
    always_ff @(posedge pixel_clk) begin
        for (int k = 0; k < STAR_COUNT; k++) begin
            if (wr_en_s && (idx_r == 8'(k))) begin
                star_x[k]     <= new_x_s;
                star_y[k]     <= new_y_s;
                star_layer[k] <= new_layer_s;
                star_phase[k] <= lfsr_r[3:0];
                star_tint[k]  <= lfsr_r[1:0];
            end else if (run_fsync_s) begin
                // y is always below AREA_V, so the wrap sum cannot overflow 12 bits
                if (star_y[k] < y_step(game_state, star_layer[k])) begin
                    star_y[k] <= star_y[k] + 12'(AREA_V) - y_step(game_state, star_layer[k]);
                end else begin
                    star_y[k] <= star_y[k] - y_step(game_state, star_layer[k]);
                end
                if (twinkle_s) begin
                    star_phase[k] <= star_phase[k] + 4'd1;
                end else begin
                    star_phase[k] <= star_phase[k];
                end
            end else begin
                star_y[k] <= star_y[k];
            end
        end
    end

    // Hit search: the highest layer wins, and on equal layers the lowest index wins
    always_comb begin
        h_u_s        = hpos;
        v_u_s        = vpos;
        pos_ok_s     = !hpos[11] && !vpos[11] && (h_u_s < 12'(AREA_H)) && (v_u_s < 12'(AREA_V));
        hit_s        = 1'b0;
        best_layer_s = 2'd0;
        colour_s     = 24'd0;
        for (int k = 0; k < STAR_COUNT; k++) begin
            if (pos_ok_s && (star_x[k] == h_u_s) && (star_y[k] == v_u_s) &&
                (!hit_s || (star_layer[k] > best_layer_s))) begin
                hit_s        = 1'b1;
                best_layer_s = star_layer[k];
                colour_s     = star_colour(star_layer[k], star_tint[k], star_phase[k]);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Registered pixel output, blanked until the table is valid
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            pixel_r  <= 24'd0;
            active_r <= 1'b0;
        end else if (init_done_r && hit_s) begin
            pixel_r  <= colour_s;
            active_r <= 1'b1;
        end else begin
            pixel_r  <= 24'd0;
            active_r <= 1'b0;
        end
    end

    assign pixel     = pixel_r;
    assign active    = active_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_parallax_starfield.sv
// tb_parallax_starfield
//   Directed stimulus for parallax_starfield with a small star table and play area.
//   The driver pushes the expected output for each cycle into a queue. The expected
//   values come either from hand-computed constants or from a behavioural star
//   model. The monitor pops one item per cycle and compares it to the registered
//   outputs.
module tb_parallax_starfield;

    localparam int          SC = 8;
    localparam int          NL = 3;
    localparam int          AH = 20;
    localparam int          AV = 12;
    localparam int          TD = 2;
    localparam logic [15:0] SD = 16'hACE1;

    logic               pixel_clk = 1'b0;
    logic               rst;
    logic               fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic [1:0]         game_state;
    logic               reseed;
    logic [2:0][7:0]    pixel;
    logic               active;
    logic               init_done;

    parallax_starfield #(
        .STAR_COUNT(SC), .LAYERS(NL), .AREA_H(AH), .AREA_V(AV),
        .TWINKLE_DIV(TD), .SEED(SD)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
        .game_state(game_state), .reseed(reseed), .pixel(pixel), .active(active),
        .init_done(init_done)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int          tag;
        logic [23:0] pix;
        logic        act;
        logic        done;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model of the star table
    int          m_x[SC], m_y[SC], m_layer[SC], m_phase[SC], m_tint[SC];
    logic [15:0] m_lfsr;
    int          m_idx, m_frame;
    bit          m_run, m_done;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Monitor: each queued item is due one rising edge after it was issued
    always @(negedge pixel_clk) begin
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (pixel !== mon_e.pix || active !== mon_e.act || init_done !== mon_e.done) begin
                n_fail++;
                $display("FAIL %s: got pixel=%06h active=%0b init_done=%0b, want pixel=%06h active=%0b init_done=%0b",
                         mon_e.name, pixel, active, init_done, mon_e.pix, mon_e.act, mon_e.done);
            end
        end
    end

    function automatic logic [23:0] ref_colour(input int layer, input int tint, input int phase);
        int base, r, g, b;
        base = 64 + 64 * layer;
        if (base > 255) base = 255;
        if (phase >= 8) base = base / 2;
        r = base; g = base; b = base;
        if (tint == 1) begin
            r = 0; g = 0;
        end else if (tint == 2) begin
            b = 0;
        end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic model_reset();
        m_lfsr  = SD;
        m_idx   = 0;
        m_frame = 0;
        m_run   = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic drive(input bit rr, input bit fs, input logic [1:0] gs, input bit rs,
                         input int h, input int v, input string nm,
                         input bit hand, input logic [23:0] hpix, input bit hact);
        exp_t e;
        int   best, st;
        @(negedge pixel_clk);
        rst = rr; fsync = fs; game_state = gs; reseed = rs;
        hpos = 12'(h); vpos = 12'(v);
        e.tag = cyc; e.name = nm; e.pix = 24'd0; e.act = 1'b0;
        if (!rr && m_done && h >= 0 && h < AH && v >= 0 && v < AV) begin
            best = -1;
            for (int k = 0; k < SC; k++)
                if (m_x[k] == h && m_y[k] == v && (best < 0 || m_layer[k] > m_layer[best])) best = k;
            if (best >= 0) begin
                e.act = 1'b1;
                e.pix = ref_colour(m_layer[best], m_tint[best], m_phase[best]);
            end
        end
        if (rr) begin
            model_reset();
        end else begin
            if (!m_run) begin
                if (rs) begin
                    m_idx = 0;
                end else begin
                    m_x[m_idx]     = int'(m_lfsr[11:0]) % AH;
                    m_y[m_idx]     = int'(m_lfsr[15:4]) % AV;
                    m_layer[m_idx] = m_idx % NL;
                    m_phase[m_idx] = int'(m_lfsr[3:0]);
                    m_tint[m_idx]  = int'(m_lfsr[1:0]);
                    if (m_idx == SC - 1) begin
                        m_run = 1'b1; m_done = 1'b1; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (rs) begin
                m_run = 1'b0; m_done = 1'b0; m_idx = 0;
            end else if (fs) begin
                for (int k = 0; k < SC; k++) begin
                    st = (gs == 2'b01) ? m_layer[k] + 1 : (gs == 2'b00) ? 1 : 0;
                    if (m_y[k] < st) m_y[k] = m_y[k] + AV - st;
                    else m_y[k] = m_y[k] - st;
                end
                if (m_frame == TD - 1) begin
                    m_frame = 0;
                    if (gs != 2'b10)
                        for (int k = 0; k < SC; k++) m_phase[k] = (m_phase[k] + 1) % 16;
                end else begin
                    m_frame++;
                end
            end
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        e.done = m_done;
        if (hand) begin
            e.pix = hpix;
            e.act = hact;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit rr, input bit fs, input logic [1:0] gs, input bit rs,
                        input int h, input int v, input string nm);
        drive(rr, fs, gs, rs, h, v, nm, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic hand(input int h, input int v, input logic [23:0] pix, input bit act, input string nm);
        drive(1'b0, 1'b0, 2'b01, 1'b0, h, v, nm, 1'b1, pix, act);
    endtask

    // Probe every star position plus out-of-area and negative coordinates
    task automatic probe_all(input logic [1:0] gs, input string nm);
        int px, py;
        for (int k = 0; k < SC; k++) begin
            px = m_x[k]; py = m_y[k];
            tick(1'b0, 1'b0, gs, 1'b0, px, py, nm);
        end
        px = m_x[0]; py = m_y[0];
        tick(1'b0, 1'b0, gs, 1'b0, -1, py, "miss_neg_h");
        tick(1'b0, 1'b0, gs, 1'b0, px, -1, "miss_neg_v");
        tick(1'b0, 1'b0, gs, 1'b0, AH, py, "miss_h_edge");
        tick(1'b0, 1'b0, gs, 1'b0, px, AV, "miss_v_edge");
        tick(1'b0, 1'b0, gs, 1'b0, -2048, -2048, "miss_min");
        tick(1'b0, 1'b0, gs, 1'b0, px - 2048, py, "miss_wrap_h");
    endtask

    // First-boot stars worked out by hand from SEED ACE1 (20x12 area, 3 layers)
    task automatic hand_probes(input string tag);
        hand(17, 6, 24'h000040, 1'b1, {tag, "_star0_blue"});
        hand(12, 11, 24'h606060, 1'b1, {tag, "_star2_half"});
        hand(3, 10, 24'hC0C0C0, 1'b1, {tag, "_star5_white"});
        hand(10, 8, 24'h404000, 1'b1, {tag, "_star4_rg_half"});
        hand(16, 6, 24'h000000, 1'b0, {tag, "_empty"});
    endtask

    initial begin
        rst = 1'b1; fsync = 1'b0; reseed = 1'b0; game_state = 2'b01; hpos = '0; vpos = '0;
        model_reset();

        repeat (3) tick(1'b1, 1'b0, 2'b01, 1'b0, 17, 6, "reset_state");
        // Fill the table; the fsync in the middle must be ignored
        for (int i = 0; i < 10; i++) tick(1'b0, (i == 3), 2'b01, 1'b0, 17, 6, "init_boot");
        hand_probes("boot");
        probe_all(2'b01, "boot_probe");

        // Play scrolling with layer-dependent steps, wrap and twinkle
        repeat (8) begin
            tick(1'b0, 1'b1, 2'b01, 1'b0, -1, -1, "play_fsync");
            probe_all(2'b01, "play_probe");
        end
        // Pause freezes y and phase
        repeat (20) tick(1'b0, 1'b1, 2'b10, 1'b0, -1, -1, "pause_fsync");
        probe_all(2'b10, "pause_probe");
        // Game over freezes y
        repeat (3) tick(1'b0, 1'b1, 2'b11, 1'b0, -1, -1, "over_fsync");
        probe_all(2'b11, "over_probe");
        // Title scrolls every layer by one
        repeat (13) begin
            tick(1'b0, 1'b1, 2'b00, 1'b0, -1, -1, "title_fsync");
            probe_all(2'b00, "title_probe");
        end

        // Reseed in RUN, then again during INIT
        tick(1'b0, 1'b0, 2'b01, 1'b1, m_x[7], m_y[7], "reseed_run");
        for (int i = 0; i < 4; i++) tick(1'b0, (i == 1), 2'b01, 1'b0, m_x[7], m_y[7], "reseed_init");
        tick(1'b0, 1'b0, 2'b01, 1'b1, m_x[6], m_y[6], "reseed_in_init");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 2'b01, 1'b0, m_x[6], m_y[6], "reseed_fill");
        probe_all(2'b01, "reseed_probe");

        // Reset during INIT regenerates the first-boot table
        tick(1'b0, 1'b0, 2'b01, 1'b1, -1, -1, "reseed_pre_rst");
        repeat (3) tick(1'b0, 1'b0, 2'b01, 1'b0, -1, -1, "init_pre_rst");
        repeat (2) tick(1'b1, 1'b0, 2'b01, 1'b0, 17, 6, "rst_mid_init");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 2'b01, 1'b0, 17, 6, "init_reboot");
        hand_probes("reboot");
        probe_all(2'b01, "reboot_probe");

        repeat (2) tick(1'b0, 1'b0, 2'b01, 1'b0, -1, -1, "idle");
        repeat (2) @(negedge pixel_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d items left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parallax_starfield.md
PARALLAX_STARFIELD -- requirements
Module: parallax_starfield

Interface
REQ-001 SHALL have parameter STAR_COUNT, default 64, number of stars (2..255).
REQ-002 SHALL have parameter LAYERS, default 3, parallax depth layers (1..4).
REQ-003 SHALL have parameter AREA_H, default 640, horizontal playable width in pixels.
REQ-004 SHALL have parameter AREA_V, default 480, vertical playable height in pixels.
REQ-005 SHALL have parameter TWINKLE_DIV, default 8, frames per twinkle phase step (1..255).
REQ-006 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR seed.
REQ-007 pixel_clk  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 fsync  in  1  one-cycle frame-start pulse.
REQ-010 hpos  in  12 signed  current pixel column.
REQ-011 vpos  in  12 signed  current pixel row.
REQ-012 game_state  in  2  00 title, 01 play, 10 pause, 11 game over.
REQ-013 reseed  in  1  one-cycle pulse, restart star generation.
REQ-014 pixel  out  3x8 array  [0]=B, [1]=G, [2]=R, registered.
REQ-015 active  out  1  registered star-hit flag, aligned with pixel.
REQ-016 init_done  out  1  high when star table valid.

Function
REQ-017 SHALL use FSM states INIT, RUN; INIT writes one star per cycle, index 0..STAR_COUNT-1, then enters RUN with init_done=1.
REQ-018 SHALL use internal 16-bit Galois LFSR (taps 16,14,13,11), loaded with SEED on reset, advancing every cycle; LFSR never reset by reseed.
REQ-019 Star k at init SHALL get x = rnd[11:0] mod AREA_H, y = rnd[15:4] mod AREA_V, layer = k mod LAYERS, twinkle phase = rnd[3:0].
REQ-020 Star colour SHALL be base intensity (64 + 64*layer) saturated to 8 bits, tinted: rnd[1:0]=00 white, 01 blue-only B, 10 R+G, 11 white.
REQ-021 reseed in RUN SHALL drop init_done next cycle and restart INIT at index 0; reseed during INIT SHALL restart index at 0.
REQ-022 fsync during INIT SHALL be ignored.
REQ-023 On fsync in RUN, star y SHALL decrease by step: play = layer+1; title = 1 for all layers; pause and game over = 0 (frozen).
REQ-024 Wrap SHALL preserve modulo: if y < step then y <= y + AREA_V - step, else y <= y - step; y always in [0, AREA_V-1]; x never changes.
REQ-025 Frame counter SHALL count fsync pulses in RUN, wrapping at TWINKLE_DIV; on wrap every star phase increments mod 16, except when game_state = pause.
REQ-026 Star with phase[3]=1 SHALL render at half intensity (each channel >>1); phase[3]=0 full.
REQ-027 Hit: hpos==x and vpos==y with both in range; negative or out-of-area positions never hit.
REQ-028 On multiple hits, highest layer wins; within equal layer, lowest index wins.
REQ-029 pixel/active SHALL be registered: latency exactly 1 pixel_clk from hpos/vpos; no hit -> pixel 0,0,0, active 0.
REQ-030 While init_done=0, active SHALL be 0 and pixel 0.
REQ-031 Arithmetic on y/step SHALL use 12-bit unsigned compare after range guarantee; no signed underflow.

Reset
REQ-032 On rst assertion, asynchronously: FSM=INIT, index=0, init_done=0, frame counter=0, LFSR=SEED, pixel=0,0,0, active=0.
REQ-033 rst mid-RUN or mid-INIT SHALL discard star table and regenerate identically (same SEED -> same sequence).
REQ-034 Star table itself needs no reset; contents undefined until written by INIT.

Verification
REQ-035 Reset release, STAR_COUNT=64 -> init_done rises exactly 64 cycles later; all stars x<640, y<480.
REQ-036 Star layer 2 at y=1, game_state=01, fsync -> y=478 (1+480-3); layer 0 at y=5 -> 4.
REQ-037 game_state=10, 20 fsyncs -> all y unchanged, all phases unchanged; game_state=00, fsync -> every y decremented by 1 (with wrap).
REQ-038 Force two stars same position, layers 0 and 2, colours distinct -> one cycle after hpos/vpos match, pixel equals layer-2 colour, active=1.
REQ-039 TWINKLE_DIV=2, star phase 7, two fsyncs in play -> phase 8, output channels halved on next hit.
REQ-040 reseed mid-RUN -> init_done low next cycle, active=0 throughout INIT, high again after STAR_COUNT cycles; rst during INIT then release -> star table identical to first-boot table.
